// File: rtl/seq_arith_8b_accum_rr_arb_pkg.sv
// ---------------------------------------------------------------------------
// seq_arith_accum_pkg : shared constants and response type for the accumulator
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package seq_arith_accum_pkg;

  localparam int NREQ_DEFAULT  = 4;
  localparam int WIDTH_DEFAULT = 8;
  localparam int ID_W_DEFAULT  = $clog2(NREQ_DEFAULT);

  typedef struct packed {
    logic [ID_W_DEFAULT-1:0]  id;
    logic [WIDTH_DEFAULT-1:0] data;
  } resp_t;

endpackage

`default_nettype wire

// File: rtl/seq_arith_8b_accum_rr_arb_if.sv
// ---------------------------------------------------------------------------
// seq_arith_8b_accum_rr_arb_if : request/response bus of the shared accumulator
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface seq_arith_8b_accum_rr_arb_if
  import seq_arith_accum_pkg::*;
#(
  parameter int NREQ  = NREQ_DEFAULT,
  parameter int WIDTH = WIDTH_DEFAULT
);

  logic [NREQ-1:0]         req_val;
  logic [NREQ-1:0]         req_rdy;
  logic [NREQ-1:0]         req_clr;
  logic [NREQ*WIDTH-1:0]   req_data;
  logic                    resp_val;
  logic                    resp_rdy;
  logic [$clog2(NREQ)-1:0] resp_id;
  logic [WIDTH-1:0]        resp_data;

  modport master (
    output req_val, req_clr, req_data, resp_rdy,
    input  req_rdy, resp_val, resp_id, resp_data
  );

  modport slave (
    input  req_val, req_clr, req_data, resp_rdy,
    output req_rdy, resp_val, resp_id, resp_data
  );

endinterface

`default_nettype wire

// File: rtl/seq_arith_8b_accum_rr_arb_rr_arb.sv
// ---------------------------------------------------------------------------
// rr_arb : round-robin arbiter, pointer advances past the winner on each grant
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rr_arb #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  wire logic            clk,
  input  wire logic            reset,
  input  wire logic [NREQ-1:0] i_req,
  input  wire logic            i_en,
  output logic      [NREQ-1:0] o_grant,
  output logic      [IDW-1:0]  o_gnt_id
);

  logic [IDW-1:0] r_ptr;
  logic           w_found;

  // NREQ is a power of two, so the IDW-bit add wraps the search naturally.
  always_comb begin
    logic [IDW-1:0] idx;
    o_grant  = '0;
    o_gnt_id = '0;
    w_found  = 1'b0;
    idx      = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = r_ptr + IDW'(k);
      if (i_en && !w_found && i_req[idx]) begin
        o_grant[idx] = 1'b1;
        o_gnt_id     = idx;
        w_found      = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr <= '0;
    end else if (w_found) begin
      r_ptr <= o_gnt_id + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/seq_arith_8b_accum_rr_arb.sv
// ---------------------------------------------------------------------------
// seq_arith_8b_accum_rr_arb : per-requester accumulators sharing one adder,
// round-robin arbitrated, with a single-entry val/rdy response register. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module seq_arith_8b_accum_rr_arb
  import seq_arith_accum_pkg::*;
#(
  parameter int NREQ  = NREQ_DEFAULT,
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  wire logic                   clk,
  input  wire logic                   reset,
  seq_arith_8b_accum_rr_arb_if.slave  bus
);

  localparam int IDW = $clog2(NREQ);

  logic [WIDTH-1:0] r_accum [NREQ];
  logic             r_resp_val;
  logic [IDW-1:0]   r_resp_id;
  logic [WIDTH-1:0] r_resp_data;

  logic [NREQ-1:0]  w_grant;
  logic [IDW-1:0]   w_gnt_id;
  logic             w_en;
  logic             w_gnt_any;
  logic [WIDTH-1:0] w_sel_data;
  logic             w_sel_clr;
  logic [WIDTH-1:0] w_new;

  // Requests are held off during reset so nothing is consumed in that cycle.
  assign w_en      = (!r_resp_val || bus.resp_rdy) && !reset;
  assign w_gnt_any = |w_grant;

  rr_arb #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .clk      (clk),
    .reset    (reset),
    .i_req    (bus.req_val),
    .i_en     (w_en),
    .o_grant  (w_grant),
    .o_gnt_id (w_gnt_id)
  );

  always_comb begin
    w_sel_data = '0;
    w_sel_clr  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (IDW'(i) == w_gnt_id) begin
        w_sel_data = bus.req_data[i*WIDTH +: WIDTH];
        w_sel_clr  = bus.req_clr[i];
      end
    end
    w_new = w_sel_clr ? w_sel_data : r_accum[w_gnt_id] + w_sel_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREQ; i++) begin
        r_accum[i] <= '0;
      end
    end else if (w_gnt_any) begin
      r_accum[w_gnt_id] <= w_new;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_resp_val  <= 1'b0;
      r_resp_id   <= '0;
      r_resp_data <= '0;
    end else if (w_gnt_any) begin
      r_resp_val  <= 1'b1;
      r_resp_id   <= w_gnt_id;
      r_resp_data <= w_new;
    end else if (bus.resp_rdy) begin
      r_resp_val  <= 1'b0;
    end
  end

  assign bus.req_rdy   = w_grant;
  assign bus.resp_val  = r_resp_val;
  assign bus.resp_id   = r_resp_id;
  assign bus.resp_data = r_resp_data;

endmodule

`default_nettype wire
